// File: rtl/uart_rx_pkg.sv
// Shared definitions for the board UART receiver: FSM states, frame constants and baud divider.
// The optional 8E1 frame format is selected with the UART_RX_PARITY_EN macro in uart_rx.sv.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  localparam int DATA_BITS = 8;
  localparam int MIN_DIV   = 8;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input plus a registered falling-edge detect.
// All flops reset to 1 so an idle-high line never produces a spurious edge out of reset.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic fall
);

  logic meta;
  logic stage;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= 1'b1;
      stage <= 1'b1;
      prev  <= 1'b1;
    end else begin
      meta  <= din;
      stage <= meta;
      prev  <= stage;
    end
  end

  assign sync = stage;
  assign fall = prev & ~stage;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: deserialises 8N1 frames (8E1 when UART_RX_PARITY_EN is defined) from RX_I
// and presents each byte on a valid/ready handshake with frame, overrun and parity error pulses.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD        = 115200
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       RX_I,
  output logic [7:0] DATA_O,
  output logic       VALID_O,
  input  logic       READY_I,
  output logic       FRAME_ERR_O,
  output logic       OVERRUN_O,
  output logic       PARITY_ERR_O
);

  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_RELOAD = CW'(DIV - 1);
  localparam logic [2:0]    LAST_BIT    = 3'(DATA_BITS - 1);

  if (DIV < MIN_DIV) begin : g_div_check
    $error("uart_rx: clock-to-baud divider is below the minimum of 8");
  end

  logic rx_sync;
  logic rx_fall;

  uart_rx_sync u_sync (
    .clk  (CLK_I),
    .rst  (RST_I),
    .din  (RX_I),
    .sync (rx_sync),
    .fall (rx_fall)
  );

  rx_state_t      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           frame_good;
  logic           frame_err;
  logic           cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_err;
  logic par_err_q;
`endif

  // Every sampling state waits for the counter to hit zero, which lands on mid-bit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_zero ? cnt_q : cnt_q - 1'b1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    frame_good = 1'b0;
    frame_err  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err    = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (rx_fall) begin
          cnt_d   = HALF_RELOAD;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (cnt_zero) begin
          if (!rx_sync) begin
            cnt_d   = FULL_RELOAD;
            bit_d   = '0;
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_DATA: begin
        if (cnt_zero) begin
          shift_d = {rx_sync, shift_q[7:1]};
          cnt_d   = FULL_RELOAD;
          if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_zero) begin
          par_err = (rx_sync != ^shift_q);
          cnt_d   = FULL_RELOAD;
          state_d = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        if (cnt_zero) begin
          if (rx_sync) begin
            frame_good = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            frame_err  = 1'b1;
            state_d    = ST_BREAK;
          end
        end
      end

      // A held-low line must return high before a new start bit is accepted.
      ST_BREAK: begin
        if (rx_sync) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A byte completing in the same cycle the old one is accepted replaces it without overrun.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      DATA_O      <= '0;
      VALID_O     <= 1'b0;
      FRAME_ERR_O <= 1'b0;
      OVERRUN_O   <= 1'b0;
    end else begin
      FRAME_ERR_O <= frame_err;
      OVERRUN_O   <= frame_good && VALID_O && !READY_I;
      if (frame_good && (!VALID_O || READY_I)) begin
        DATA_O  <= shift_q;
        VALID_O <= 1'b1;
      end else if (VALID_O && READY_I) begin
        VALID_O <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err;
    end
  end

  assign PARITY_ERR_O = par_err_q;
`else
  assign PARITY_ERR_O = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at the default 12 MHz / 115200 configuration.
// Follows UART_RX_PARITY_EN so the same bench drives 8N1 or 8E1 frames.
module tb_uart_rx;

  localparam int CLK_FREQ_HZ = 12000000;
  localparam int BAUD        = 115200;
  localparam int DIV         = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_EN   = 1'b1;
`else
  localparam bit PARITY_EN   = 1'b0;
`endif
  localparam int LATENCY     = 2 + 1 + DIV / 2 + 9 * DIV + 1 + (PARITY_EN ? DIV : 0);
  localparam int TIMEOUT     = LATENCY + 4 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int total_checks = 0;
  int passed_checks = 0;

  int valid_rises = 0;
  int valid_cycles = 0;
  int ferr_cycles = 0;
  int ovr_cycles = 0;
  int perr_cycles = 0;
  logic valid_prev = 1'b0;

  uart_rx #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .BAUD        (BAUD)
  ) dut (
    .CLK_I        (clk),
    .RST_I        (rst),
    .RX_I         (rx),
    .DATA_O       (data),
    .VALID_O      (valid),
    .READY_I      (ready),
    .FRAME_ERR_O  (frame_err),
    .OVERRUN_O    (overrun),
    .PARITY_ERR_O (parity_err)
  );

  always #5 clk = ~clk;

  // Output activity is tallied on the falling edge, away from the active edge.
  always @(negedge clk) begin
    valid_prev <= valid;
    if (valid && !valid_prev) valid_rises <= valid_rises + 1;
    if (valid)      valid_cycles <= valid_cycles + 1;
    if (frame_err)  ferr_cycles  <= ferr_cycles + 1;
    if (overrun)    ovr_cycles   <= ovr_cycles + 1;
    if (parity_err) perr_cycles  <= perr_cycles + 1;
  end

  initial begin
    #(10 * 80000);
    $display("[TB] FAIL watchdog: simulation still running after 80000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int actual, input int expected,
                             input int tol = 0);
    total_checks++;
    if (actual >= expected - tol && actual <= expected + tol) begin
      passed_checks++;
    end else begin
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) +/- %0d",
               tag, actual, actual, expected, expected, tol);
    end
  endtask

  // Drive the line for a number of cycles; always returns 1 time unit after a rising edge.
  task automatic applyStimulus(input logic level, input int cycles);
    rx = level;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input logic [7:0] byte_val, input logic stop_bit,
                           input logic parity_flip);
    applyStimulus(1'b0, DIV);
    for (int i = 0; i < 8; i++) applyStimulus(byte_val[i], DIV);
    if (PARITY_EN) applyStimulus((^byte_val) ^ parity_flip, DIV);
    applyStimulus(stop_bit, DIV);
  endtask

  int base_rises, base_vcyc, base_ferr, base_ovr, base_perr;
  int lat;
  logic [7:0] seen;

  task automatic snapshot();
    base_rises = valid_rises;
    base_vcyc  = valid_cycles;
    base_ferr  = ferr_cycles;
    base_ovr   = ovr_cycles;
    base_perr  = perr_cycles;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", int'(valid), 0);
    checkOutput("reset_data", int'(data), 8'h00);
    checkOutput("reset_frame_err", int'(frame_err), 0);
    checkOutput("reset_overrun", int'(overrun), 0);
    checkOutput("reset_parity_err", int'(parity_err), 0);
    rst = 1'b0;
    applyStimulus(1'b1, 2 * DIV);

    // 0x55 with the consumer always ready: latency and single-cycle valid.
    $display("[TB] frame 0x55, latency");
    snapshot();
    lat  = TIMEOUT;
    seen = 8'h00;
    fork
      sendFrame(8'h55, 1'b1, 1'b0);
      begin
        int n = 0;
        while (n < TIMEOUT) begin
          @(posedge clk);
          #1;
          n++;
          if (valid) begin
            lat  = n;
            seen = data;
            break;
          end
        end
      end
    join
    applyStimulus(1'b1, DIV);
    checkOutput("latency_0x55", lat, LATENCY, 2);
    checkOutput("data_0x55", int'(seen), 8'h55);
    checkOutput("valid_width_0x55", valid_cycles - base_vcyc, 1);
    checkOutput("no_ferr_0x55", ferr_cycles - base_ferr, 0);
    checkOutput("no_ovr_0x55", ovr_cycles - base_ovr, 0);
    checkOutput("no_perr_0x55", perr_cycles - base_perr, 0);

    // Back-to-back 0xA3, 0x0F with the consumer stalled: second byte overruns.
    $display("[TB] back-to-back 0xA3 0x0F, overrun");
    ready = 1'b0;
    snapshot();
    sendFrame(8'hA3, 1'b1, 1'b0);
    sendFrame(8'h0F, 1'b1, 1'b0);
    applyStimulus(1'b1, 4);
    checkOutput("held_data_0xA3", int'(data), 8'hA3);
    checkOutput("held_valid", int'(valid), 1);
    checkOutput("overrun_pulses", ovr_cycles - base_ovr, 1);
    checkOutput("b2b_no_ferr", ferr_cycles - base_ferr, 0);
    ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("valid_after_accept", int'(valid), 0);
    applyStimulus(1'b1, DIV);

    // 0x3C with a low stop bit, line held low for three more bit times.
    $display("[TB] frame error and break");
    snapshot();
    sendFrame(8'h3C, 1'b0, 1'b0);
    applyStimulus(1'b0, 3 * DIV);
    checkOutput("ferr_pulse_width", ferr_cycles - base_ferr, 1);
    applyStimulus(1'b1, 3 * DIV);
    checkOutput("break_no_valid", valid_rises - base_rises, 0);
    checkOutput("break_no_ovr", ovr_cycles - base_ovr, 0);
    checkOutput("break_data_kept", int'(data), 8'hA3);

    // 20-cycle glitch on the idle line.
    $display("[TB] start-bit glitch");
    snapshot();
    applyStimulus(1'b0, 20);
    applyStimulus(1'b1, 2 * DIV);
    checkOutput("glitch_no_valid", valid_rises - base_rises, 0);
    checkOutput("glitch_no_ferr", ferr_cycles - base_ferr, 0);
    checkOutput("glitch_no_perr", perr_cycles - base_perr, 0);

    // Reset pulse in the middle of bit 4 of 0xFF; bits 0..4 are all high.
    $display("[TB] reset mid-frame");
    snapshot();
    applyStimulus(1'b0, DIV);
    applyStimulus(1'b1, 4 * DIV + DIV / 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midreset_valid", int'(valid), 0);
    checkOutput("midreset_data", int'(data), 8'h00);
    checkOutput("midreset_frame_err", int'(frame_err), 0);
    applyStimulus(1'b1, 6 * DIV);
    checkOutput("midreset_no_delivery", valid_rises - base_rises, 0);
    checkOutput("midreset_no_ferr", ferr_cycles - base_ferr, 0);

    snapshot();
    sendFrame(8'h81, 1'b1, 1'b0);
    applyStimulus(1'b1, DIV);
    checkOutput("after_reset_data_0x81", int'(data), 8'h81);
    checkOutput("after_reset_delivered", valid_rises - base_rises, 1);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones, so even parity needs a 1; send 0 instead.
    $display("[TB] parity error on 0x07");
    snapshot();
    sendFrame(8'h07, 1'b1, 1'b1);
    applyStimulus(1'b1, DIV);
    checkOutput("perr_pulse_width", perr_cycles - base_perr, 1);
    checkOutput("perr_data_0x07", int'(data), 8'h07);
    checkOutput("perr_delivered", valid_rises - base_rises, 1);
    checkOutput("perr_no_ferr", ferr_cycles - base_ferr, 0);
`endif

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
